ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Shares the single-port 4x8 register-file RAM between two requesters: requester 0 (pixel/kernel loader) and requester 1 (convolution engine).
- Issues at most one RAM access per cycle and drives the RAM's data_in, address and write_enable ports.
- Arbitration is round-robin with an optional lock for back-to-back bursts.
- Read data is registered and returned to the winning requester one cycle after the grant.

Parameters:
- DATA_W, 8, RAM word width
- ADDR_W, 2, RAM address width (4 words)

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  synchronous active-high reset
- req0  input  1  requester 0 access request
- we0  input  1  requester 0: 1 = write, 0 = read
- lock0  input  1  requester 0 holds the grant while req0 stays high
- addr0  input  ADDR_W  requester 0 address
- wdata0  input  DATA_W  requester 0 write data
- gnt0  output  1  requester 0 access issued this cycle
- rvalid0  output  1  requester 0 read data valid
- rdata0  output  DATA_W  requester 0 read data
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above for requester 1
- ram_data_in  output  DATA_W  to RAM data_in
- ram_address  output  ADDR_W  to RAM address
- ram_write_enable  output  1  to RAM write_enable
- ram_data_out  input  DATA_W  from RAM data_out (combinational read)

Behaviour:
- Single clock clk; reset clr is synchronous and active-high.
- Reset values:
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0
  - ram_write_enable = 0, ram_address = 0, ram_data_in = 0
  - rr pointer = requester 0
  - FSM = IDLE
- Handshake:
  - A requester raises req with we/addr/wdata stable and holds them until it sees gnt high in the same cycle.
  - gnt is combinational from the current req, pointer and FSM state.
  - An access completes on the clock edge where gnt = 1.
- RAM drive:
  - When gnt_k = 1: ram_address = addr_k, ram_data_in = wdata_k, ram_write_enable = we_k.
  - With no grant: all three are 0.
  - The write commits at the edge of the grant cycle.
- Read return:
  - On a granted read, ram_data_out is registered into rdata_k at that edge.
  - rvalid_k is high for exactly one cycle, the cycle after the grant. Latency = 1.
  - rdata_k holds its value until the next read by requester k.
  - No rvalid is produced for writes.
- FSM states:
  - IDLE:
    - Only one req high: grant it.
    - Both high: grant the requester indicated by the rr pointer.
    - On a grant to k: the pointer moves to the other requester. If lock_k = 1, next state is LOCKk.
  - LOCKk:
    - req_k high: always grant k, even if the other requester is requesting. The pointer does not move.
    - Stay in LOCKk while req_k && lock_k. Return to IDLE when lock_k = 0 in a granted cycle, or when req_k = 0.
    - If req_k = 0 in LOCKk: no grant that cycle and next state is IDLE. The other requester waits one cycle.
- Boundaries:
  - At most one gnt per cycle; gnt0 & gnt1 is never 1.
  - A read granted the cycle after a write to the same address returns the new data.
  - Both requesters idle: no RAM activity and the pointer is unchanged.
  - clr mid-operation: FSM to IDLE, pointer to 0, any pending rvalid is squashed (0 next cycle), and the RAM is not written in the clr cycle because gnt is forced to 0.
  - Address wrap is not applicable: the full ADDR_W space is valid.

Test Plan:
- clr for 2 cycles, then release with no req -> all outputs 0, ram_write_enable = 0 for 5 cycles.
- req0 write addr=2 data=0xA5, then req1 read addr=2 -> gnt0 in cycle 0, gnt1 in cycle 1, rvalid1 = 1 in cycle 2 with rdata1 = 0xA5, rvalid0 stays 0.
- req0 and req1 both held high with reads for 4 cycles, lock = 0 -> grants alternate 0, 1, 0, 1; rvalid follows each grant by 1 cycle.
- req0 with lock0 = 1 writing addr 0..3 (0x11, 0x22, 0x33, 0x44) while req1 is held high -> gnt0 for 4 consecutive cycles with lock0 dropped on the 4th; gnt1 on the 5th cycle; a subsequent requester 1 read of addr 3 returns 0x44.
- Read granted to requester 1 at cycle n with clr asserted at cycle n+1 -> rvalid1 = 0 at n+2, FSM in IDLE, pointer at 0.
- Simultaneous req0/req1 immediately after reset -> gnt0 first (pointer reset value), then gnt1.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if
// Bundles the two requester ports and the single-port RAM port of the arbiter.
//   master : requester/RAM side
//            (drives req/we/lock/addr/wdata and ram_data_out,
//             receives gnt/rvalid/rdata and the RAM drive signals)
//   slave  : arbiter side (the reverse direction of every signal)
interface ram_access_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              req0;
    logic              we0;
    logic              lock0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic              lock1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic [DATA_W-1:0] ram_data_in;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_write_enable;
    logic [DATA_W-1:0] ram_data_out;

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, lock1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  ram_data_in, ram_address, ram_write_enable,
        output ram_data_out
    );

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, lock1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output ram_data_in, ram_address, ram_write_enable,
        input  ram_data_out
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one single-port RAM between two requesters. It issues at most one
// access per cycle. Arbitration is round-robin, and a requester can set a lock
// to keep the grant for back-to-back bursts. Read data is registered and
// returned one cycle after the grant.
// Ports:
//   clk : system clock, rising edge
//   clr : synchronous active-high reset
//   bus : slave modport. It carries the requester handshakes (req/we/lock/
//         addr/wdata -> gnt/rvalid/rdata) and the RAM drive signals
//         (ram_data_in, ram_address, ram_write_enable <- ram_data_out).
module ram_access_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    ram_access_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ptr;       // 0: requester 0 wins a tie, 1: requester 1
    logic              w_ptr_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] w_ram_data_in;
    logic [ADDR_W-1:0] w_ram_address;
    logic              w_ram_write_enable;

    // State register and round-robin pointer
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Grant decision, next state and next pointer
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (clr) begin
            // Forcing the grants low keeps the RAM from being written during reset.
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req0 && (!bus.req1 || (r_ptr == 1'b0))) begin
                        w_gnt0    = 1'b1;
                        w_ptr_nxt = 1'b1;
                        if (bus.lock0) begin
                            w_state_nxt = ST_LOCK0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (bus.req1) begin
                        w_gnt1    = 1'b1;
                        w_ptr_nxt = 1'b0;
                        if (bus.lock1) begin
                            w_state_nxt = ST_LOCK1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                // A locked requester keeps the grant and the pointer does not
                // move. If it drops req, that cycle gets no grant.
                ST_LOCK0: begin
                    if (bus.req0) begin
                        w_gnt0 = 1'b1;
                        if (bus.lock0) begin
                            w_state_nxt = ST_LOCK0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOCK1: begin
                    if (bus.req1) begin
                        w_gnt1 = 1'b1;
                        if (bus.lock1) begin
                            w_state_nxt = ST_LOCK1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // RAM port mux: the winner drives the RAM, and all signals are zero with no grant
    always_comb begin
        w_ram_data_in      = {DATA_W{1'b0}};
        w_ram_address      = {ADDR_W{1'b0}};
        w_ram_write_enable = 1'b0;
        if (w_gnt0) begin
            w_ram_data_in      = bus.wdata0;
            w_ram_address      = bus.addr0;
            w_ram_write_enable = bus.we0;
        end else if (w_gnt1) begin
            w_ram_data_in      = bus.wdata1;
            w_ram_address      = bus.addr1;
            w_ram_write_enable = bus.we1;
        end else begin
            w_ram_data_in      = {DATA_W{1'b0}};
            w_ram_address      = {ADDR_W{1'b0}};
            w_ram_write_enable = 1'b0;
        end
    end

    // Read return: capture RAM data on a granted read and pulse rvalid for one cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= {DATA_W{1'b0}};
            r_rdata1  <= {DATA_W{1'b0}};
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_gnt0 && !bus.we0) begin
                r_rdata0 <= bus.ram_data_out;
            end else begin
                r_rdata0 <= r_rdata0;
            end
            if (w_gnt1 && !bus.we1) begin
                r_rdata1 <= bus.ram_data_out;
            end else begin
                r_rdata1 <= r_rdata1;
            end
        end
    end

    assign bus.gnt0             = w_gnt0;
    assign bus.gnt1             = w_gnt1;
    assign bus.rvalid0          = r_rvalid0;
    assign bus.rvalid1          = r_rvalid1;
    assign bus.rdata0           = r_rdata0;
    assign bus.rdata1           = r_rdata1;
    assign bus.ram_data_in      = w_ram_data_in;
    assign bus.ram_address      = w_ram_address;
    assign bus.ram_write_enable = w_ram_write_enable;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// Directed bench for ram_access_arbiter. It models the 4x8 RAM (combinational
// read, write on the clock edge) and checks the handshake and data against
// hand-computed values.
module tb_ram_access_arbiter;
    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;
    logic [7:0] mem [0:3];

    ram_access_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    ram_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model
    assign bus.ram_data_out = mem[bus.ram_address];
    always @(posedge clk) begin
        if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = 2'd0; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = 2'd0; bus.wdata1 = 8'h00;
    endtask

    task automatic chk_mutex();
        chk("gnt_mutex", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        idle_reqs();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;

        // Idle after reset: everything quiet for 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rst_gnt0",    32'(bus.gnt0), 32'd0);
            chk("rst_gnt1",    32'(bus.gnt1), 32'd0);
            chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
            chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
            chk("rst_rdata0",  32'(bus.rdata0), 32'd0);
            chk("rst_rdata1",  32'(bus.rdata1), 32'd0);
            chk("rst_ram_we",  32'(bus.ram_write_enable), 32'd0);
            chk("rst_ram_addr",32'(bus.ram_address), 32'd0);
            chk("rst_ram_din", 32'(bus.ram_data_in), 32'd0);
            step();
        end

        // Write by requester 0, then read back by requester 1
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'hA5;
        #1;
        chk("wr_gnt0", 32'(bus.gnt0), 32'd1);
        chk("wr_gnt1", 32'(bus.gnt1), 32'd0);
        chk("wr_ram_we", 32'(bus.ram_write_enable), 32'd1);
        chk("wr_ram_addr", 32'(bus.ram_address), 32'd2);
        chk("wr_ram_din", 32'(bus.ram_data_in), 32'hA5);
        step();
        idle_reqs();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd2;
        #1;
        chk("rd_gnt1", 32'(bus.gnt1), 32'd1);
        chk("rd_ram_we", 32'(bus.ram_write_enable), 32'd0);
        chk("rd_ram_addr", 32'(bus.ram_address), 32'd2);
        chk("wr_no_rvalid0", 32'(bus.rvalid0), 32'd0);
        step();
        idle_reqs();
        #1;
        chk("rd_rvalid1", 32'(bus.rvalid1), 32'd1);
        chk("rd_rdata1", 32'(bus.rdata1), 32'hA5);
        chk("rd_rvalid0", 32'(bus.rvalid0), 32'd0);
        step();
        #1;
        chk("rd_rvalid1_pulse", 32'(bus.rvalid1), 32'd0);
        chk("rd_rdata1_hold", 32'(bus.rdata1), 32'hA5);
        step();

        // Both reading for 4 cycles: grants alternate 0,1,0,1
        bus.req0 = 1'b1; bus.addr0 = 2'd2;
        bus.req1 = 1'b1; bus.addr1 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_mutex();
            chk("rr_gnt0", 32'(bus.gnt0), 32'((i % 2) == 0));
            chk("rr_gnt1", 32'(bus.gnt1), 32'((i % 2) == 1));
            chk("rr_rvalid0", 32'(bus.rvalid0), 32'((i > 0) && ((i % 2) == 1)));
            chk("rr_rvalid1", 32'(bus.rvalid1), 32'((i > 0) && ((i % 2) == 0)));
            step();
        end
        idle_reqs();
        #1;
        chk("rr_last_rvalid1", 32'(bus.rvalid1), 32'd1);
        chk("rr_last_rdata1", 32'(bus.rdata1), 32'h00);
        chk("rr_rdata0", 32'(bus.rdata0), 32'hA5);
        step();

        // Locked burst by requester 0 while requester 1 waits
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd3;
        for (int i = 0; i < 4; i++) begin
            bus.req0 = 1'b1; bus.we0 = 1'b1; bus.lock0 = (i < 3) ? 1'b1 : 1'b0;
            bus.addr0 = 2'(i);
            bus.wdata0 = 8'(8'h11 * (i + 1));
            #1;
            chk_mutex();
            chk("lk_gnt0", 32'(bus.gnt0), 32'd1);
            chk("lk_ram_addr", 32'(bus.ram_address), 32'(i));
            chk("lk_ram_din", 32'(bus.ram_data_in), 32'(8'h11 * (i + 1)));
            step();
        end
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0;
        #1;
        chk("lk_gnt1_after", 32'(bus.gnt1), 32'd1);
        chk("lk_ram_addr_r", 32'(bus.ram_address), 32'd3);
        step();
        idle_reqs();
        #1;
        chk("lk_rvalid1", 32'(bus.rvalid1), 32'd1);
        chk("lk_rdata1", 32'(bus.rdata1), 32'h44);
        step();

        // Locked requester drops req: a cycle with no grant, then the other is served
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 2'd1;
        bus.req1 = 1'b1; bus.addr1 = 2'd0;
        #1;
        chk("ld_gnt0", 32'(bus.gnt0), 32'd1);
        step();
        bus.req0 = 1'b0; bus.lock0 = 1'b0;
        #1;
        chk("ld_gap_gnt0", 32'(bus.gnt0), 32'd0);
        chk("ld_gap_gnt1", 32'(bus.gnt1), 32'd0);
        chk("ld_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("ld_rdata0", 32'(bus.rdata0), 32'h22);
        step();
        #1;
        chk("ld_gnt1", 32'(bus.gnt1), 32'd1);
        step();
        idle_reqs();
        #1;
        chk("ld_rdata1", 32'(bus.rdata1), 32'h11);
        step();

        // clr right after a read grant squashes rvalid and blocks RAM writes
        bus.req1 = 1'b1; bus.addr1 = 2'd3;
        #1;
        chk("cl_gnt1", 32'(bus.gnt1), 32'd1);
        step();
        idle_reqs();
        clr = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd0; bus.wdata0 = 8'hFF;
        #1;
        chk("cl_rvalid1_pre", 32'(bus.rvalid1), 32'd1);
        chk("cl_gnt0", 32'(bus.gnt0), 32'd0);
        chk("cl_ram_we", 32'(bus.ram_write_enable), 32'd0);
        step();
        clr = 1'b0;
        idle_reqs();
        #1;
        chk("cl_rvalid1", 32'(bus.rvalid1), 32'd0);
        chk("cl_rdata1", 32'(bus.rdata1), 32'd0);
        step();

        // Simultaneous requests after reset: requester 0 first, then 1
        bus.req0 = 1'b1; bus.addr0 = 2'd0;
        bus.req1 = 1'b1; bus.addr1 = 2'd3;
        #1;
        chk("ar_gnt0", 32'(bus.gnt0), 32'd1);
        chk("ar_gnt1", 32'(bus.gnt1), 32'd0);
        step();
        bus.req0 = 1'b0;
        #1;
        chk("ar_gnt1_next", 32'(bus.gnt1), 32'd1);
        chk("ar_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("ar_rdata0", 32'(bus.rdata0), 32'h11);
        step();
        idle_reqs();
        #1;
        chk("ar_rvalid1", 32'(bus.rvalid1), 32'd1);
        chk("ar_rdata1", 32'(bus.rdata1), 32'h44);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
